// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - decoded MIDI event inputs and per-voice outputs of the voice allocator
interface voice_allocator_if #(
    parameter int N      = 8,
    parameter int NOTE_W = 7,
    parameter int VEL_W  = 7
);
    logic                en;
    logic                note_on;
    logic                note_off;
    logic [NOTE_W-1:0]   note;
    logic [VEL_W-1:0]    velocity;
    logic                sustain;
    logic                all_off;
    logic                busy;
    logic                dropped;
    logic                stolen;
    logic [N-1:0]        voice_start;
    logic [N-1:0]        voice_stop;
    logic [N-1:0]        voice_active;
    logic [N-1:0]        voice_held;
    logic [N*NOTE_W-1:0] voice_note;
    logic [N*VEL_W-1:0]  voice_vel;

    modport master (
        output en, note_on, note_off, note, velocity, sustain, all_off,
        input  busy, dropped, stolen, voice_start, voice_stop,
               voice_active, voice_held, voice_note, voice_vel
    );

    modport slave (
        input  en, note_on, note_off, note, velocity, sustain, all_off,
        output busy, dropped, stolen, voice_start, voice_stop,
               voice_active, voice_held, voice_note, voice_vel
    );
endinterface

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator: retrigger, first-free, oldest-steal, note-off and sustain release
module voice_allocator #(
    parameter int N      = 8,
    parameter int NOTE_W = 7,
    parameter int VEL_W  = 7,
    parameter int AGE_W  = 8
) (
    input logic              MHz10,
    input logic              rst,
    voice_allocator_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    state_t state, state_next;

    logic [IW-1:0]     idx;
    logic              ev_off, ev_sus;
    logic [NOTE_W-1:0] ev_note;
    logic [VEL_W-1:0]  ev_vel;
    logic              match_ok, free_ok, old_ok;
    logic [IW-1:0]     match_idx, free_idx, old_idx;
    logic [AGE_W-1:0]  old_age;
    logic [N-1:0]      rel_mask;

    logic [NOTE_W-1:0] note_r [N];
    logic [VEL_W-1:0]  vel_r  [N];
    logic [AGE_W-1:0]  age_r  [N];
    logic [N-1:0]      active, held, start_q, stop_q;
    logic              busy_q, dropped_q, stolen_q, sus_q, sus_pend;

    logic              idle, event_in, live, accept, scan_step, commit_on, commit_off;
    logic              steal, sus_fall;
    logic [IW-1:0]     tgt;

    always_ff @(posedge MHz10 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.all_off) begin
            state_next = IDLE;
        end else if (bus.en) begin
            case (state)
                IDLE:    if (event_in) state_next = SCAN;
                SCAN:    if (idx == IW'(N-1)) state_next = COMMIT;
                COMMIT:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        idle       = (state == IDLE);
        event_in   = bus.note_on | bus.note_off;
        live       = bus.en & ~bus.all_off;
        accept     = live & idle & event_in;
        scan_step  = live & (state == SCAN);
        commit_on  = live & (state == COMMIT) & ~ev_off;
        commit_off = live & (state == COMMIT) & ev_off;
        steal      = ~match_ok & ~free_ok;
        tgt        = match_ok ? match_idx : (free_ok ? free_idx : old_idx);
        sus_fall   = sus_q & ~bus.sustain;
    end

    always_ff @(posedge MHz10 or posedge rst) begin
        if (rst) begin
            idx <= '0; ev_off <= 1'b0; ev_sus <= 1'b0; ev_note <= '0; ev_vel <= '0;
            match_ok <= 1'b0; free_ok <= 1'b0; old_ok <= 1'b0;
            match_idx <= '0; free_idx <= '0; old_idx <= '0; old_age <= '0;
            rel_mask <= '0; active <= '0; held <= '0; start_q <= '0; stop_q <= '0;
            busy_q <= 1'b0; dropped_q <= 1'b0; stolen_q <= 1'b0;
            sus_q <= 1'b0; sus_pend <= 1'b0;
            for (int i = 0; i < N; i++) begin
                note_r[i] <= '0; vel_r[i] <= '0; age_r[i] <= '0;
            end
        end else if (bus.all_off) begin
            stop_q <= active; start_q <= '0; stolen_q <= 1'b0; dropped_q <= 1'b0;
            busy_q <= 1'b0; active <= '0; held <= '0;
            sus_pend <= 1'b0; sus_q <= bus.sustain;
            for (int i = 0; i < N; i++) begin
                note_r[i] <= '0; vel_r[i] <= '0; age_r[i] <= '0;
            end
        end else if (!bus.en) begin
            start_q <= '0; stop_q <= '0; stolen_q <= 1'b0; dropped_q <= 1'b0;
        end else begin
            start_q   <= '0;
            stop_q    <= '0;
            stolen_q  <= 1'b0;
            dropped_q <= event_in & ~idle;
            busy_q    <= (state_next != IDLE);
            sus_q     <= bus.sustain;
            sus_pend  <= sus_fall | (sus_pend & ~idle);

            // Pedal release shares the IDLE cycle with a possible event accept.
            if (idle && sus_pend) begin
                stop_q <= active & ~held;
                active <= active & held;
            end

            if (accept) begin
                ev_off  <= bus.note_off;
                ev_sus  <= bus.sustain;
                ev_note <= bus.note;
                ev_vel  <= bus.velocity;
                idx     <= '0;
                match_ok <= 1'b0; free_ok <= 1'b0; old_ok <= 1'b0;
                rel_mask <= '0;
            end

            if (scan_step) begin
                idx <= idx + 1'b1;
                if (ev_off) begin
                    if (held[idx] && note_r[idx] == ev_note) rel_mask[idx] <= 1'b1;
                end else begin
                    if (active[idx] && note_r[idx] == ev_note && !match_ok) begin
                        match_ok <= 1'b1; match_idx <= idx;
                    end
                    if (!active[idx] && !free_ok) begin
                        free_ok <= 1'b1; free_idx <= idx;
                    end
                    // Strict '>' keeps the lowest index among equally old voices.
                    if (active[idx] && (!old_ok || age_r[idx] > old_age)) begin
                        old_ok <= 1'b1; old_idx <= idx; old_age <= age_r[idx];
                    end
                end
            end

            if (commit_on) begin
                for (int i = 0; i < N; i++) begin
                    if (IW'(i) == tgt)                        age_r[i] <= '0;
                    else if (active[i] && age_r[i] != AGE_MAX) age_r[i] <= age_r[i] + 1'b1;
                end
                note_r[tgt]  <= ev_note;
                vel_r[tgt]   <= ev_vel;
                active[tgt]  <= 1'b1;
                held[tgt]    <= 1'b1;
                start_q[tgt] <= 1'b1;
                if (steal) begin
                    stop_q[tgt] <= 1'b1;
                    stolen_q    <= 1'b1;
                end
            end

            if (commit_off) begin
                held <= held & ~rel_mask;
                if (!ev_sus) begin
                    active <= active & ~rel_mask;
                    stop_q <= rel_mask;
                end
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.dropped      = dropped_q;
    assign bus.stolen       = stolen_q;
    assign bus.voice_start  = start_q;
    assign bus.voice_stop   = stop_q;
    assign bus.voice_active = active;
    assign bus.voice_held   = held;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign bus.voice_note[g*NOTE_W +: NOTE_W] = note_r[g];
        assign bus.voice_vel[g*VEL_W +: VEL_W]    = vel_r[g];
    end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Parametrised polyphonic voice allocator for the synth core; the next generation of the note-start arbitration stage. It turns decoded MIDI note-on/note-off events into per-voice start/stop pulses and per-voice note/velocity registers for `N` oscillator voices. Over first-free arbitration it adds same-note retrigger, oldest-voice stealing, note-off matching and sustain-pedal release. It sits between the MIDI decoder and the per-voice counter bank.

## Interface
- `N`, 8: number of voices, 2..128
- `NOTE_W`, 7: note number width
- `VEL_W`, 7: velocity width
- `AGE_W`, 8: per-voice age counter width, saturating

- `MHz10`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  clock enable; low freezes all state and pulses read 0
- `note_on`  in  1  one-cycle note-on event
- `note_off`  in  1  one-cycle note-off event
- `note`  in  NOTE_W  note number, valid with event
- `velocity`  in  VEL_W  velocity, valid with `note_on`
- `sustain`  in  1  sustain pedal level, synchronous
- `all_off`  in  1  panic/clear, level, acts regardless of `en`
- `busy`  out  1  scan in progress; events are not accepted
- `dropped`  out  1  one-cycle pulse: an event arrived while busy
- `stolen`  out  1  one-cycle pulse: a note-on took a sounding voice
- `voice_start`  out  N  one-hot start pulse
- `voice_stop`  out  N  multi-hot stop pulse
- `voice_active`  out  N  voice sounding (gate)
- `voice_held`  out  N  key physically down
- `voice_note`  out  N*NOTE_W  packed note per voice, voice i at `[i*NOTE_W +: NOTE_W]`
- `voice_vel`  out  N*VEL_W  packed velocity per voice

## Operation
- Every output resets to 0. States reset to IDLE. Ages reset to 0. `sus_pend` resets to 0.
- States are IDLE, SCAN, and COMMIT.
- IDLE, event present:
  - Latch the event (note, velocity, kind), set idx=0 and go to SCAN.
  - If `note_on` and `note_off` are both high, note_off wins and note_on is discarded without a `dropped` pulse.
- SCAN examines voice idx each cycle for idx=0..N-1, then goes to COMMIT.
  - Note-on tracks three candidates:
    - match: the lowest voice that is active with an equal note;
    - free: the lowest inactive voice;
    - oldest: the active voice with the maximum age, lowest index on ties.
  - Note-off builds two masks over voices that are held with an equal note:
    - `rel_mask` for those voices;
    - `stop_mask` = `rel_mask` when `sustain`=0, otherwise empty.
- COMMIT, note-on, target selection in priority order:
  - match: retrigger; no `stolen`, no stop pulse.
  - free.
  - oldest: set `voice_stop[i]`=1 and `voice_start[i]`=1 in the same cycle, with `stolen`=1.
- COMMIT, note-on, target update:
  - Write note and velocity; set active=1 and held=1; age=0.
  - Every other active voice increments its age, saturating at 2^AGE_W-1.
- COMMIT, note-off:
  - Clear held for `rel_mask`.
  - Clear active for `stop_mask`.
  - Pulse `voice_stop` = `stop_mask`.
  - Ages are unchanged.
- COMMIT always returns to IDLE.
- Sustain:
  - A registered falling edge of `sustain` sets `sus_pend`.
  - In any IDLE cycle with `sus_pend` set:
    - pulse `voice_stop` for active&~held;
    - clear those active bits;
    - clear `sus_pend`.
  - This runs concurrently with accepting a new event in the same cycle.
  - A note-off scan that started while `sustain`=1 leaves released voices active; the pending release catches them.
- `all_off`, highest priority, any state:
  - Pulse `voice_stop` = `voice_active`.
  - Clear active, held, note, velocity, ages and `sus_pend`.
  - Abort any scan and go to IDLE.
  - An event in the same cycle is ignored.
- `en`=0: no state changes, scans pause, events are ignored (no `dropped`), and all pulses read 0.

## Timing
- All outputs are registered.
- Event sampled at edge k:
  - `busy`=1 after edge k through edge k+N+1;
  - start/stop/stolen pulses are high for exactly the one cycle after edge k+N+1;
  - the updated `voice_note`, `voice_vel`, `voice_active` and `voice_held` are visible from that same cycle.
- Throughput: one event per N+2 cycles. With N=75 at 10 MHz this is 7.7 µs, well below the 320 µs MIDI byte time.
- An event sampled while `busy`=1 produces `dropped` in the next cycle; state is unaffected.
- Sustain release: `voice_stop` is high in the cycle after the first IDLE edge following the falling edge.
  - No scan in flight: 2 cycles after `sustain` falls.
- `all_off` at edge j: `voice_stop` is high for the cycle after j; `busy`=0 after j.

## Test plan
- Reset check, N=4: assert `rst` mid-scan -> all outputs 0 immediately; `busy`=0; the first event after release is accepted.
- Allocation, N=4:
  - note_on 60/100 -> after edge k+5, `voice_start`=0001, voice_note[0]=60, voice_vel[0]=100, `voice_active`=0001, `busy` low for the next cycle;
  - then note_on 62 -> `voice_start`=0010.
- Stealing, N=4: note_on 60, 62, 64, 65, then 67 -> `voice_start`=0001, `voice_stop`=0001, `stolen`=1, voice_note[0]=67; the next note_on 69 steals voice 1.
- Retrigger: note_on 62 vel 50, then note_on 62 vel 90 -> same voice restarts, velocity becomes 90, `stolen`=0, no stop pulse.
- Sustain:
  - `sustain`=1, note_on 60, note_off 60 -> `voice_held`=0, `voice_active`=1, no stop;
  - drop `sustain` -> `voice_stop`=0001 two cycles later, `voice_active`=0.
- Collisions:
  - note_on 64 while busy -> `dropped` for one cycle, outputs unchanged;
  - `all_off` mid-scan with voices 0 and 2 active -> `voice_stop`=0101 next cycle, `busy`=0, no `voice_start`.
